serial_word_tx: RTL
===================

// Module: serial_word_tx
// PURPOSE
//   Transmit side of the single-bit serial link between pipeline stages.
//   Accepts a parallel word over a valid/ready handshake and drives it onto one
//   registered output line as a frame: start bit, DATA_W data bits LSB first,
//   stop bit. The matching receiver samples that line and rebuilds the word.
// PARAMETERS
//   DATA_W      8   data bits per frame; must be >= 1
//   BIT_CYCLES  1   clock cycles each bit is held on the line; must be >= 1
// PORTS
//   clk       in   1       clock; all logic on the rising edge
//   rst       in   1       asynchronous reset, active-high
//   in_data   in   DATA_W  word to send; sampled on accept
//   in_valid  in   1       in_data holds a word to send
//   in_ready  out  1       block can accept a word this cycle
//   o         out  1       serial line; idles high
//   busy      out  1       a frame is in progress
// BEHAVIOUR
//   - Reset (async assert, sync-safe release): state=IDLE, o=1, busy=0,
//     shift register and counters cleared. in_ready=0 while rst is high.
//   - FSM states: IDLE, START, DATA, STOP.
//   - in_ready = (state==IDLE) && !rst. This is combinational from state only.
//     It does not depend on in_valid.
//   - Accept = in_valid && in_ready. On accept, latch in_data into shift_reg,
//     go to START, and clear cyc_cnt and bit_cnt.
//   - in_valid without in_ready: no effect. The source holds in_data stable.
//   - o and busy are registered. They change on the edge that enters a state:
//     - START:  o=0.
//     - DATA:   o=shift_reg[0]. Shift right by 1 each time a bit ends.
//     - STOP:   o=1.
//     - IDLE:   o=1, busy=0.
//     - busy=1 in START, DATA and STOP.
//   - cyc_cnt counts 0..BIT_CYCLES-1 within a bit. The bit ends when
//     cyc_cnt==BIT_CYCLES-1, and cyc_cnt then wraps to 0.
//     Width = max(1, $clog2(BIT_CYCLES)).
//   - Transitions:
//     - START -> DATA at end of bit.
//     - DATA -> STOP at end of bit when bit_cnt==DATA_W-1; otherwise bit_cnt++.
//     - STOP -> IDLE at end of bit.
//   - bit_cnt width = max(1, $clog2(DATA_W)). No wrap beyond DATA_W-1.
//   - Timing:
//     - Accept at edge N: o=0 from edge N+1.
//     - Data bit k drives o from edge N+1+(k+1)*BIT_CYCLES.
//     - Stop bit from edge N+1+(DATA_W+1)*BIT_CYCLES.
//     - Back in IDLE at edge N+1+(DATA_W+2)*BIT_CYCLES.
//   - Back-to-back: in_ready rises once IDLE is reached. An accept in that
//     cycle starts the next frame on the following edge. So there is >= 1 idle
//     cycle (o=1) between frames and a full-rate frame period of
//     (DATA_W+2)*BIT_CYCLES+1 cycles.
//   - Reset mid-frame: the frame is aborted immediately and o returns to 1. The
//     receiver sees a truncated frame. Nothing is retransmitted.
//   - in_data changes after accept have no effect on the frame in flight.
// TESTING
//   1 Reset: hold rst 3 cycles -> o=1, busy=0, in_ready=0. Release -> in_ready=1
//     next cycle.
//   2 DATA_W=8, BIT_CYCLES=1, send 0xA5 -> o sequence 0,1,0,1,0,0,1,0,1,1.
//     busy=1 for exactly 10 cycles, then IDLE.
//   3 BIT_CYCLES=3, send 0x01 -> start held 3 cycles, bit0=1 for 3 cycles,
//     bits1..7=0 for 21 cycles, stop for 3 cycles. Total 30 busy cycles.
//   4 in_valid held high with 0xFF then 0x00 -> second accept in the first IDLE
//     cycle after stop. Exactly one o=1 idle cycle between the frames.
//   5 Change in_data every cycle after accept of 0x3C -> o still carries 0x3C.
//     No accept while busy (in_ready=0).
//   6 Assert rst in data bit 4 of 0x55 -> o=1 and busy=0 same cycle (async).
//     After release the next accept of 0x81 sends a clean, complete frame.

Source files
------------

// File: rtl/serial_word_tx.sv
// Serial link transmitter: frames a parallel word as start bit, DATA_W data bits
// (LSB first) and stop bit on a single registered line that idles high.
module serial_word_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              o,
    output logic              busy
);

    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [CYC_W-1:0]  cyc_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic              o_q;
    logic              busy_q;
    logic              accept;
    logic              bit_end;

    // Ready is gated by rst so no word can be accepted while reset is held.
    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign bit_end  = (cyc_cnt_q == CYC_LAST);
    assign shift_d  = shift_q >> 1;

    assign o    = o_q;
    assign busy = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            cyc_cnt_q <= '0;
            bit_cnt_q <= '0;
            o_q       <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shift_q   <= in_data;
                        cyc_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        o_q       <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_START;
                    end else begin
                        o_q    <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cyc_cnt_q <= '0;
                        o_q       <= shift_q[0];
                        state_q   <= ST_DATA;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cyc_cnt_q <= '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            o_q     <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            // The line shows the bit that becomes LSB after the shift.
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            shift_q   <= shift_d;
                            o_q       <= shift_d[0];
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cyc_cnt_q <= '0;
                        o_q       <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                    end
                end
                default: begin
                    o_q     <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
